// File: rtl/write_buffer_store_pkg.sv
// Shared cache constants plus the write-buffer index/tag helpers and valid-update decode.
package write_buffer_store_pkg;

  localparam int BURST_COUNT = 7;
  localparam int DATASLICE   = 8;
  localparam int BYTE_LANES  = 4;
  localparam int WORD_LSB    = 2;
  localparam int WORD_W      = 3;
  localparam int LINE_OFF_W  = 5;

  typedef enum logic [1:0] {
    VOP_NONE,
    VOP_INVAL,
    VOP_ALLOC,
    VOP_MERGE
  } vop_e;

  // The write-buffer entry index sits right above the line offset; the tag is everything higher.
  function automatic int wb_tag_lsb(input int idx_w);
    return LINE_OFF_W + idx_w;
  endfunction

  function automatic vop_e wb_decode_vop(input logic write, input logic tagv_en,
                                         input logic tagval_out, input logic val_en);
    vop_e op;
    op = VOP_NONE;
    if (write) begin
      if (tagv_en)     op = tagval_out ? VOP_ALLOC : VOP_INVAL;
      else if (val_en) op = VOP_MERGE;
    end
    return op;
  endfunction

endpackage

// File: rtl/wb_byte_ram.sv
// Line data store: one 8-bit array per byte lane so each lane infers its own block RAM.
module wb_byte_ram
  import write_buffer_store_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [AW-1:0]                    addr,
  input  logic [BYTE_LANES-1:0]            we,
  input  logic [BYTE_LANES*DATASLICE-1:0]  wdata,
  input  logic                             re,
  output logic [BYTE_LANES*DATASLICE-1:0]  rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
      logic [DATASLICE-1:0] mem [DEPTH];
      logic [DATASLICE-1:0] rd_reg;

      always_ff @(posedge Clk) begin
        if (we[gi]) mem[addr] <= wdata[gi*DATASLICE +: DATASLICE];
      end

      // Registered read samples the array before this edge's write lands (read-before-write).
      always_ff @(posedge Clk) begin
        if (Reset)   rd_reg <= '0;
        else if (re) rd_reg <= mem[addr];
      end

      assign rdata[gi*DATASLICE +: DATASLICE] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/write_buffer_store.sv
// Write-buffer storage: tags, tag-valid and byte-valid bits, line data, occupancy and lookup outputs.
module write_buffer_store
  import write_buffer_store_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int WORDS   = BURST_COUNT + 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  input  logic [31:0] MemDataIn,
  input  logic [2:0]  Count,
  input  logic        wb_write,
  input  logic        wb_read,
  input  logic        wb_mem_en,
  input  logic        wb_val_en,
  input  logic        wb_tag_en,
  input  logic        wb_tagv_en,
  input  logic        wb_tagval_out,
  input  logic        wb_flush,
  input  logic        MergeData,
  input  logic [3:0]  wb_mbe,
  input  logic [5:0]  wb_flush_cnt,
  output logic        wb_full,
  output logic        wb_tagval_in,
  output logic        wb_tag_match,
  output logic [3:0]  wb_data_valid,
  output logic [31:0] wb_dout,
  output logic [31:0] wb_merged,
  output logic [31:0] wb_flush_addr
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_LSB = wb_tag_lsb(IDX_W);
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int CNT_W   = IDX_W + 1;
  localparam int RAM_AW  = IDX_W + WORD_W;

  logic [IDX_W-1:0]      addr_idx;
  logic [IDX_W-1:0]      sel;
  logic [WORD_W-1:0]     wsel;
  logic [TAG_W-1:0]      addr_tag;
  vop_e                  vop;
  logic                  rd_strobe;
  logic [BYTE_LANES-1:0] ram_we;

  logic [ENTRIES-1:0]    tagv_reg;
  logic [TAG_W-1:0]      tag_mem [ENTRIES];
  logic [BYTE_LANES-1:0] bval_reg [ENTRIES][WORDS];
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;
  logic                  full_reg;
  logic                  tagval_reg;
  logic                  match_reg;
  logic [BYTE_LANES-1:0] dv_reg;
  logic [31:0]           dout_ram;
  logic                  unused_bits;

  assign addr_idx = Addr[LINE_OFF_W +: IDX_W];
  assign addr_tag = Addr[TAG_LSB +: TAG_W];

  // A conflict flush (flush_cnt[5]) drains the entry the CPU address maps to.
  always_comb begin
    sel = addr_idx;
    if (wb_flush && !wb_flush_cnt[5]) sel = wb_flush_cnt[3 +: IDX_W];
  end

  assign wsel      = (wb_flush || MergeData) ? Count : Addr[WORD_LSB +: WORD_W];
  assign vop       = wb_decode_vop(wb_write, wb_tagv_en, wb_tagval_out, wb_val_en);
  assign rd_strobe = wb_read | wb_tag_en | wb_val_en;
  assign ram_we    = (wb_write && wb_mem_en && !wb_flush) ? wb_mbe : '0;

  wb_byte_ram #(
    .DEPTH (ENTRIES * WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .Clk   (Clk),
    .Reset (Reset),
    .addr  ({sel, wsel}),
    .we    (ram_we),
    .wdata (DataIn),
    .re    (rd_strobe & wb_mem_en),
    .rdata (dout_ram)
  );

  // Occupancy only moves on an actual tag-valid transition of the selected entry.
  always_comb begin
    cnt_next = cnt_reg;
    if (vop == VOP_ALLOC && !tagv_reg[sel])     cnt_next = cnt_reg + CNT_W'(1);
    else if (vop == VOP_INVAL && tagv_reg[sel]) cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tagv_reg <= '0;
      cnt_reg  <= '0;
      full_reg <= 1'b0;
      for (int e = 0; e < ENTRIES; e++)
        for (int w = 0; w < WORDS; w++)
          bval_reg[e][w] <= '0;
    end else begin
      case (vop)
        VOP_INVAL: begin
          tagv_reg[sel] <= 1'b0;
          for (int w = 0; w < WORDS; w++) bval_reg[sel][w] <= '0;
        end
        VOP_ALLOC: begin
          tagv_reg[sel] <= 1'b1;
          for (int w = 0; w < WORDS; w++)
            bval_reg[sel][w] <= (WORD_W'(w) == wsel) ? wb_mbe : '0;
        end
        VOP_MERGE: bval_reg[sel][wsel] <= bval_reg[sel][wsel] | wb_mbe;
        default: ;
      endcase
      cnt_reg  <= cnt_next;
      full_reg <= (cnt_reg == CNT_W'(ENTRIES));
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && vop == VOP_ALLOC && wb_tag_en) tag_mem[sel] <= addr_tag;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tagval_reg <= 1'b0;
      match_reg  <= 1'b0;
      dv_reg     <= '0;
    end else if (rd_strobe) begin
      tagval_reg <= tagv_reg[sel];
      match_reg  <= (tag_mem[sel] == addr_tag);
      dv_reg     <= bval_reg[sel][wsel];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTE_LANES; gi++) begin : g_merge
      assign wb_merged[gi*DATASLICE +: DATASLICE] = dv_reg[gi] ? dout_ram[gi*DATASLICE +: DATASLICE]
                                                               : MemDataIn[gi*DATASLICE +: DATASLICE];
    end
  endgenerate

  assign wb_full       = full_reg;
  assign wb_tagval_in  = tagval_reg;
  assign wb_tag_match  = match_reg;
  assign wb_data_valid = dv_reg;
  assign wb_dout       = dout_ram;
  assign wb_flush_addr = {tag_mem[sel], sel, {LINE_OFF_W{1'b0}}};

  assign unused_bits = ^{Addr[WORD_LSB-1:0], wb_flush_cnt[2:0]};

endmodule
